// File: rtl/lif_scheduler_if.sv
// lif_scheduler_if: control, data and status bundle of the time-multiplexed
// LIF scheduler. The master side requests sweeps, writes the threshold and
// selects a neuron for readout; the slave side (the scheduler) returns
// membrane state, status flags and the spike vector.

interface lif_scheduler_if #(
    parameter int N_NEURONS = 4
);
    localparam int IDX_W = $clog2(N_NEURONS);

    logic                   start;
    logic [4*N_NEURONS-1:0] current;
    logic                   thr_wr;
    logic [3:0]             thr_data;
    logic [IDX_W-1:0]       rd_idx;
    logic [3:0]             rd_state;
    logic                   busy;
    logic                   done;
    logic [N_NEURONS-1:0]   spikes;
    logic [3:0]             threshold;

    modport master (
        output start,
        output current,
        output thr_wr,
        output thr_data,
        output rd_idx,
        input  rd_state,
        input  busy,
        input  done,
        input  spikes,
        input  threshold
    );

    modport slave (
        input  start,
        input  current,
        input  thr_wr,
        input  thr_data,
        input  rd_idx,
        output rd_state,
        output busy,
        output done,
        output spikes,
        output threshold
    );
endinterface

// File: rtl/lif_scheduler.sv
// lif_scheduler: time-multiplexed leaky integrate-and-fire controller.
// A single shared LIF update steps through N_NEURONS virtual neurons, one
// neuron per clock, each time a sweep is started. The block owns the firing
// threshold and collects one spike vector per sweep.
//
// Optional feature macro: LIF_REFRACTORY_EN
//   defined   - every neuron carries a 3-bit refractory counter loaded with
//               REFRAC_SWEEPS on a spike; while it is nonzero the neuron's
//               slot holds the state at 0 and only counts down.
//   undefined - no counters; a neuron integrates again in the very next
//               sweep after it spikes.

module lif_scheduler #(
    parameter int N_NEURONS     = 4,
    parameter int REFRAC_SWEEPS = 2
) (
    input logic            clk,
    input logic            reset,
    lif_scheduler_if.slave bus
);
    localparam int               IDX_W    = $clog2(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]     idx;
    logic [3:0]           mem      [N_NEURONS];
    logic [3:0]           cur_snap [N_NEURONS];
    logic [N_NEURONS-1:0] work_spikes;
    logic [N_NEURONS-1:0] work_next;
    logic [N_NEURONS-1:0] spikes_reg;
    logic [3:0]           thr_reg;

    logic [3:0] s_now;
    logic [3:0] c_now;
    logic [3:0] s_new;
    logic       spike_now;
    logic       last_slot;

`ifdef LIF_REFRACTORY_EN
    localparam logic [2:0] REFRAC_LOAD = 3'(REFRAC_SWEEPS);

    logic [2:0] refrac [N_NEURONS];
    logic [2:0] refrac_now;
    logic [2:0] refrac_new;
`else
    logic [2:0] unused_refrac;
    assign unused_refrac = 3'(REFRAC_SWEEPS);
`endif

    assign last_slot = (idx == LAST_IDX);

    // State register: synchronous active-low reset returns the sweep FSM to IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is honoured only in IDLE, one UPDATE cycle per neuron.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                if (last_slot) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: busy covers the whole sweep, done marks the single DONE cycle.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            UPDATE: begin
                bus.busy = 1'b1;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
                bus.done = 1'b0;
            end
        endcase
    end

    // Shared LIF rule for the neuron in the current slot, evaluated on its pre-update state.
    always_comb begin
        s_now     = mem[idx];
        c_now     = cur_snap[idx];
        spike_now = 1'b0;
        s_new     = c_now + (s_now >> 1);
`ifdef LIF_REFRACTORY_EN
        refrac_now = refrac[idx];
        refrac_new = refrac_now;
        if (refrac_now != 3'd0) begin
            s_new      = 4'd0;
            refrac_new = refrac_now - 3'd1;
        end else if (s_now >= thr_reg) begin
            spike_now  = 1'b1;
            s_new      = 4'd0;
            refrac_new = REFRAC_LOAD;
        end
`else
        if (s_now >= thr_reg) begin
            spike_now = 1'b1;
            s_new     = 4'd0;
        end
`endif
        work_next      = work_spikes;
        work_next[idx] = spike_now;
    end

    // Datapath: snapshot and threshold capture in IDLE, one neuron written back per UPDATE edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx         <= '0;
            thr_reg     <= 4'd8;
            spikes_reg  <= '0;
            work_spikes <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem[i]      <= 4'd0;
                cur_snap[i] <= 4'd0;
`ifdef LIF_REFRACTORY_EN
                refrac[i]   <= 3'd0;
`endif
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.thr_wr) begin
                        thr_reg <= bus.thr_data;
                    end
                    if (bus.start) begin
                        for (int i = 0; i < N_NEURONS; i++) begin
                            cur_snap[i] <= bus.current[4*i +: 4];
                        end
                        work_spikes <= '0;
                        idx         <= '0;
                    end
                end
                UPDATE: begin
                    mem[idx]    <= s_new;
`ifdef LIF_REFRACTORY_EN
                    refrac[idx] <= refrac_new;
`endif
                    work_spikes <= work_next;
                    if (last_slot) begin
                        idx        <= '0;
                        spikes_reg <= work_next;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Readout mux: an index past the last neuron reads as zero.
    always_comb begin
        bus.rd_state = 4'd0;
        if (int'(bus.rd_idx) < N_NEURONS) begin
            bus.rd_state = mem[bus.rd_idx];
        end
    end

    assign bus.spikes    = spikes_reg;
    assign bus.threshold = thr_reg;

endmodule

// File: tb/tb_lif_scheduler.sv
// tb_lif_scheduler: self-checking bench for lif_scheduler. Directed sweeps
// from the block's documented behaviour followed by randomized sweeps, all
// compared against a behavioural per-neuron model kept in this file.

module tb_lif_scheduler;
    localparam int N     = 4;
    localparam int R     = 2;
    localparam int IDX_W = $clog2(N);

    logic clk;
    logic reset;

    lif_scheduler_if #(.N_NEURONS(N)) bus ();

    lif_scheduler #(
        .N_NEURONS    (N),
        .REFRAC_SWEEPS(R)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks     = 0;
    int failures   = 0;
    int done_count = 0;

    int           model_state [N];
    int           model_thr;
    logic [N-1:0] model_spikes;
`ifdef LIF_REFRACTORY_EN
    int           model_refrac [N];
`endif

    int plan_n0 [4] = '{5, 7, 8, 0};
    int plan_sp [4] = '{0, 0, 0, 1};
`ifdef LIF_REFRACTORY_EN
    int ref_sp [6] = '{0, 1, 0, 0, 0, 1};
    int ref_st [6] = '{4, 0, 0, 0, 4, 0};
`endif

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count done pulses so ignored or aborted sweeps can be detected.
    always @(negedge clk) begin
        if (reset && bus.done) begin
            done_count++;
        end
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic readState(input int i, output logic [3:0] v);
        bus.rd_idx = IDX_W'(i);
        #1;
        v = bus.rd_state;
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            model_state[i] = 0;
`ifdef LIF_REFRACTORY_EN
            model_refrac[i] = 0;
`endif
        end
        model_thr    = 8;
        model_spikes = '0;
    endtask

    // One sweep of the LIF rule over all neurons using plain integer arithmetic.
    task automatic modelSweep(input logic [4*N-1:0] cur, output logic [N-1:0] sp);
        sp = '0;
        for (int i = 0; i < N; i++) begin
            int c;
            bit resting;
            c       = int'(cur[4*i +: 4]);
            resting = 1'b0;
`ifdef LIF_REFRACTORY_EN
            if (model_refrac[i] > 0) begin
                resting         = 1'b1;
                model_state[i]  = 0;
                model_refrac[i] = model_refrac[i] - 1;
            end
`endif
            if (!resting) begin
                if (model_state[i] >= model_thr) begin
                    model_state[i] = 0;
                    sp[i]          = 1'b1;
`ifdef LIF_REFRACTORY_EN
                    model_refrac[i] = R;
`endif
                end else begin
                    model_state[i] = (c + model_state[i] / 2) % 16;
                end
            end
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        modelReset();
    endtask

    task automatic writeThr(input logic [3:0] v);
        @(negedge clk);
        bus.thr_wr   = 1'b1;
        bus.thr_data = v;
        @(negedge clk);
        bus.thr_wr = 1'b0;
        model_thr  = int'(v);
        checkOutput("thr_write", bus.threshold, model_thr);
    endtask

    // Run one sweep; optionally write the threshold with start and poke start/thr_wr while busy.
    task automatic applyStimulus(input logic [4*N-1:0] cur, input bit do_thr, input logic [3:0] thr_val, input bit poke);
        logic [N-1:0] prev_spikes;
        logic [N-1:0] exp_spikes;
        int           exp_state [N];
        int           k;
        logic [3:0]   st;
        logic [3:0]   poke_thr;
        prev_spikes = model_spikes;
        if (do_thr) begin
            model_thr = int'(thr_val);
        end
        modelSweep(cur, exp_spikes);
        for (int i = 0; i < N; i++) begin
            exp_state[i] = model_state[i];
        end
        model_spikes = exp_spikes;
        poke_thr = (model_thr == 2) ? 4'd9 : 4'd2;

        @(negedge clk);
        bus.current  = cur;
        bus.start    = 1'b1;
        bus.thr_wr   = do_thr;
        bus.thr_data = thr_val;
        @(negedge clk);
        k           = 1;
        bus.start   = 1'b0;
        bus.thr_wr  = 1'b0;
        bus.current = (4*N)'($urandom);
        checkOutput("busy_rise", bus.busy, 1);
        checkOutput("spikes_hold", bus.spikes, prev_spikes);
        while (!bus.done && k < N + 8) begin
            @(negedge clk);
            k++;
            if (k >= 2 && k <= N + 1) begin
                readState(k - 2, st);
                checkOutput("state_slot", st, exp_state[k-2]);
            end
            if (poke && (k == 2 || k == N + 1)) begin
                bus.start    = 1'b1;
                bus.thr_wr   = 1'b1;
                bus.thr_data = poke_thr;
            end else begin
                bus.start  = 1'b0;
                bus.thr_wr = 1'b0;
            end
        end
        checkOutput("latency", k, N + 1);
        checkOutput("spikes", bus.spikes, exp_spikes);
        checkOutput("threshold", bus.threshold, model_thr);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.thr_wr = 1'b0;
        checkOutput("busy_fall", bus.busy, 0);
        checkOutput("done_single", bus.done, 0);
    endtask

    // Main sequence: reset, directed scenarios, then randomized sweeps.
    initial begin
        logic [3:0] st;
        int         dc;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.current  = '0;
        bus.thr_wr   = 1'b0;
        bus.thr_data = 4'd0;
        bus.rd_idx   = '0;
        modelReset();

        doReset();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            readState(i, st);
            checkOutput("reset_state", st, 0);
        end
        checkOutput("reset_thr", bus.threshold, 8);
        checkOutput("reset_spikes", bus.spikes, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);

        $display("[TB] leak and fire, threshold 8, current0=5");
        for (int s = 0; s < 4; s++) begin
            applyStimulus(16'h0005, 1'b0, 4'd0, 1'b0);
            readState(0, st);
            checkOutput("plan_n0_state", st, plan_n0[s]);
            checkOutput("plan_n0_spike", bus.spikes, plan_sp[s]);
        end

        $display("[TB] threshold write and busy-time write");
        doReset();
        writeThr(4'd4);
        applyStimulus(16'h0040, 1'b0, 4'd0, 1'b0);
        readState(1, st);
        checkOutput("thr4_state", st, 4);
        checkOutput("thr4_nospike", bus.spikes, 0);
        applyStimulus(16'h0040, 1'b0, 4'd0, 1'b1);
        checkOutput("thr4_spike", bus.spikes, 4'b0010);
        checkOutput("thr_busy_ignored", bus.threshold, 4);

        $display("[TB] wraparound at threshold 15");
        doReset();
        writeThr(4'd15);
        applyStimulus(16'h0A00, 1'b0, 4'd0, 1'b0);
        readState(2, st);
        checkOutput("wrap_first", st, 10);
        applyStimulus(16'h0F00, 1'b0, 4'd0, 1'b0);
        readState(2, st);
        checkOutput("wrap_second", st, 4);
        checkOutput("wrap_nospike", bus.spikes, 0);

        $display("[TB] start while busy and reset mid-sweep");
        dc = done_count;
        applyStimulus(16'h3172, 1'b0, 4'd0, 1'b1);
        repeat (N + 3) @(negedge clk);
        checkOutput("done_count", done_count - dc, 1);

        @(negedge clk);
        bus.current = 16'h5555;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        dc = done_count;
        repeat (N + 3) @(negedge clk);
        checkOutput("abort_no_done", done_count - dc, 0);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_spikes", bus.spikes, 0);
        checkOutput("abort_thr", bus.threshold, 8);
        for (int i = 0; i < N; i++) begin
            readState(i, st);
            checkOutput("abort_state", st, 0);
        end

`ifdef LIF_REFRACTORY_EN
        $display("[TB] refractory behaviour");
        doReset();
        writeThr(4'd4);
        for (int s = 0; s < 6; s++) begin
            applyStimulus(16'h0004, 1'b0, 4'd0, 1'b0);
            checkOutput("refrac_spike", bus.spikes[0], ref_sp[s]);
            readState(0, st);
            checkOutput("refrac_state", st, ref_st[s]);
        end
`endif

        $display("[TB] randomized sweeps");
        doReset();
        for (int n = 0; n < 40; n++) begin
            logic [4*N-1:0] cur;
            logic [3:0]     tv;
            bit             wt;
            cur = (4*N)'($urandom);
            tv  = 4'($urandom_range(0, 15));
            wt  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                writeThr(4'($urandom_range(0, 15)));
            end
            applyStimulus(cur, wt, tv, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
